// File: rtl/ahbl_sram_if.sv
// AHB-Lite bus bundle between a single master and the SRAM slave.
interface ahbl_sram_if;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst,
    output hprot, hmastlock, htrans, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst,
    input  hprot, hmastlock, htrans, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahbl_sram.sv
// AHB-Lite SRAM slave: word array, byte lanes, wait states,
// two-cycle ERROR response for illegal transfers.
module ahbl_sram_slave #(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  ahbl_sram_if.slave  bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [1:0]    size_q;
  logic [31:0]   mem_q [MEM_DEPTH];

  logic          rdy;
  logic          accept;
  logic          err;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] idx;

  assign rdy = (state_q == S_IDLE) || (state_q == S_DATA) ||
               (state_q == S_ERR2);

  assign err = (bus.hsize > 3'd2) ||
               (bus.hsize == 3'd1 && bus.haddr[0]) ||
               (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00) ||
               (bus.haddr[31:2] >= 30'(MEM_DEPTH));

  // an address phase in the reset cycle is dropped
  assign accept = bus.hsel && bus.htrans[1] && rdy && !hreset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!accept) begin
          state_d = S_IDLE;
        end else if (err) begin
          state_d = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          cnt_d   = 2'd0;
        end else begin
          state_d = S_DATA;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'(WAIT_STATES - 1)) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (accept) begin
      addr_q  <= bus.haddr[AW+1:0];
      write_q <= bus.hwrite;
      size_q  <= bus.hsize[1:0];
    end
  end

  assign idx = addr_q[AW+1:2];
  assign we  = (state_q == S_DATA) && write_q && !hreset;

  always_comb begin
    be = 4'b1111;
    unique case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  // combinational read sees a write committed one edge earlier
  assign bus.hrdata = (state_q == S_DATA && !write_q) ?
                      mem_q[idx] : 32'd0;
  assign bus.hresp  = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign bus.hready = rdy;

  logic unused_ok;
  assign unused_ok = ^{bus.hburst, bus.hprot,
                       bus.hmastlock, bus.htrans[0]};
endmodule

// File: doc/ahbl_sram_slave.md
AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Interface
REQ-001 The block SHALL have the parameter MEM_DEPTH, default 1024, giving the number of 32-bit words (4 KiB) and addressed by haddr[log2(MEM_DEPTH)+1:2].
REQ-002 The block SHALL have the parameter WAIT_STATES, default 1, legal range 0..3, giving the number of extra hready=0 cycles in every non-error data phase.
REQ-003 hclk  input  1  the single clock, rising edge; every state element is clocked on it.
REQ-004 hreset  input  1  reset, synchronous and active-high.
REQ-005 hsel  input  1  slave select, sampled in the address phase.
REQ-006 haddr  input  32  byte address, sampled in the address phase.
REQ-007 hwrite  input  1  1 = write, 0 = read.
REQ-008 hsize  input  3  transfer size: 0 = byte, 1 = halfword, 2 = word.
REQ-009 hburst  input  3  ignored.
REQ-010 hprot  input  4  ignored.
REQ-011 hmastlock  input  1  ignored.
REQ-012 htrans  input  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
REQ-013 hwdata  input  32  write data, sampled in the final data-phase cycle.
REQ-014 hready  output  1  transfer done / bus ready; this block is the sole slave on its bus, so this output is also the address-phase qualifier.
REQ-015 hresp  output  1  0 = OKAY, 1 = ERROR.
REQ-016 hrdata  output  32  read data.

Function
REQ-017 An address phase SHALL be accepted when hsel=1, htrans[1]=1 and hready=1 in the same cycle; on acceptance haddr, hwrite and hsize are latched.
REQ-018 IDLE/BUSY transfers, or cycles with hsel=0, SHALL produce no data phase and leave hready=1, hresp=0.
REQ-019 The control FSM SHALL have five states, with hready=1 in IDLE/DATA/ERR2 and hready=0 in WAIT/ERR1: IDLE (no pending data phase), WAIT (counting wait states), DATA (final OKAY cycle), ERR1, ERR2.
REQ-020 On an accepted erroneous transfer the FSM SHALL go to ERR1; on an accepted legal transfer it SHALL go to WAIT if WAIT_STATES>0, else to DATA; with no acceptance it SHALL go to IDLE from IDLE, DATA or ERR2.
REQ-021 WAIT SHALL last exactly WAIT_STATES cycles and then go to DATA; ERR1 SHALL always go to ERR2.
REQ-022 A transfer SHALL be erroneous if any of the following holds: hsize>2; halfword with haddr[0]=1; word with haddr[1:0]!=0; word index >= MEM_DEPTH.
REQ-023 hresp SHALL be 1 in ERR1 and ERR2 only, giving the two-cycle ERROR response.
REQ-024 An erroneous write SHALL NOT modify memory, and hrdata SHALL be 0 during an error response.
REQ-025 A write SHALL commit on the clock edge ending DATA, using hwdata and little-endian byte lanes selected by the latched hsize and haddr[1:0]; unselected lanes keep their value.
REQ-026 A read SHALL drive the full addressed word on hrdata in DATA, and hrdata SHALL be 0 in every other state.
REQ-027 A new transfer accepted in DATA or ERR2 SHALL be handled back-to-back with no idle cycle inserted.
REQ-028 A read whose data phase immediately follows a write data phase to the same word SHALL return the newly written bytes, so with WAIT_STATES=0 the implementation forwards or reads late.
REQ-029 Memory contents SHALL NOT be initialised by reset.

Reset
REQ-030 While hreset=1 at a rising edge, the FSM SHALL go to IDLE and the wait counter SHALL clear; from the next cycle the outputs SHALL be hready=1, hresp=0, hrdata=0.
REQ-031 Reset asserted during WAIT or ERR1 SHALL abort the pending transfer, no write SHALL commit, and any address phase presented in the reset cycle SHALL NOT be accepted.

Verification
REQ-032 WAIT_STATES=1: word write of 0xDEADBEEF to 0x10, then a word read of 0x10 -> each data phase shows hready 0 then 1, hresp=0, and the read returns 0xDEADBEEF.
REQ-033 WAIT_STATES=0: back-to-back NONSEQ byte write 0xAA to 0x13, then a word read of 0x10 -> the read returns 0xAAADBEEF in the very next cycle (forwarding check).
REQ-034 Word read of 0x2 (misaligned) followed by a word read of 0x4000 (out of range) -> each gives hready=0/hresp=1, then hready=1/hresp=1, and memory is unchanged.
REQ-035 Halfword write 0x1234 to 0x16 with hsize=3 in a second write -> the first updates bytes 2..3 of word 0x14 only; the second gives ERROR and no write.
REQ-036 hreset asserted in the WAIT cycle of a write of 0x55 to 0x20 -> the next cycle shows hready=1, hresp=0, hrdata=0; a later read of 0x20 returns the old value.
REQ-037 htrans=BUSY with hsel=1, then hsel=0 with NONSEQ -> no data phase occurs, hready stays 1, and hrdata stays 0.
